// File: rtl/regfile_pkg.sv
// Shared types and sizes for the 32 x 32-bit register file sequencer.
// Imported by the arbiter, its interface and the top level.
package regfile_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;
   localparam int RF_DEPTH  = 32;

   typedef enum logic {
      S_INIT,
      S_RUN
   } rf_ctl_state_t;

   // Pointer width for an N-way round robin; never zero.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile32_port_arbiter_if.sv
// Request, response and register-file bundle of the port arbiter.
// Signal suffixes are from the arbiter's point of view.
interface regfile32_port_arbiter_if
   import regfile_pkg::*;
#(
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);

   logic [NUM_RD-1:0]           rd_req_valid_i;
   logic [NUM_RD*RF_ADDR_W-1:0] rd_req_addr_i;
   logic [NUM_RD-1:0]           rd_req_ready_o;
   logic [NUM_RD-1:0]           rd_rsp_valid_o;
   logic [RF_DATA_W-1:0]        rd_rsp_data_o;

   logic [NUM_WR-1:0]           wr_req_valid_i;
   logic [NUM_WR*RF_ADDR_W-1:0] wr_req_addr_i;
   logic [NUM_WR*RF_DATA_W-1:0] wr_req_data_i;
   logic [NUM_WR-1:0]           wr_req_ready_o;

   logic [RF_ADDR_W-1:0]        rf_source_o;
   logic [RF_DATA_W-1:0]        rf_source_data_i;
   logic [RF_ADDR_W-1:0]        rf_dest_o;
   logic [RF_DATA_W-1:0]        rf_data_w_o;
   logic                        rf_dest_we_o;

   logic                        init_done_o;

   modport slave (
      input  rd_req_valid_i,
      input  rd_req_addr_i,
      output rd_req_ready_o,
      output rd_rsp_valid_o,
      output rd_rsp_data_o,
      input  wr_req_valid_i,
      input  wr_req_addr_i,
      input  wr_req_data_i,
      output wr_req_ready_o,
      output rf_source_o,
      input  rf_source_data_i,
      output rf_dest_o,
      output rf_data_w_o,
      output rf_dest_we_o,
      output init_done_o
   );

   modport master (
      output rd_req_valid_i,
      output rd_req_addr_i,
      input  rd_req_ready_o,
      input  rd_rsp_valid_o,
      input  rd_rsp_data_o,
      output wr_req_valid_i,
      output wr_req_addr_i,
      output wr_req_data_i,
      input  wr_req_ready_o,
      input  rf_source_o,
      output rf_source_data_i,
      input  rf_dest_o,
      input  rf_data_w_o,
      input  rf_dest_we_o,
      input  init_done_o
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: search starts at ptr_i and wraps.
// advance_i low suppresses every grant.
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int N = 2,
   localparam int PW = ptr_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   input  logic          advance_i,
   output logic [N-1:0]  grant_o
);

   logic          found;
   logic [PW-1:0] idx;

   // First requester at or after the pointer wins.
   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr_i) + k) % N);
         if (advance_i && !found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile32_port_arbiter.sv
// Clears the register file after reset, then round-robin shares its
// read and write ports; read data is registered with write bypass.
module regfile32_port_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_RD  = 2,
   parameter int NUM_WR  = 2,
   parameter bit ZERO_R0 = 1'b0
) (
   input logic                    core_clock_i,
   input logic                    core_reset_i,
   regfile32_port_arbiter_if.slave bus
);

   localparam int RPW = ptr_w(NUM_RD);
   localparam int WPW = ptr_w(NUM_WR);

   rf_ctl_state_t        state_q;
   logic [RF_ADDR_W-1:0] cnt_q;
   logic [RPW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [WPW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [NUM_RD-1:0]    rsp_valid_q;
   logic [RF_DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic                 done_q;

   logic                 run;
   logic [NUM_RD-1:0]    rd_grant;
   logic [NUM_WR-1:0]    wr_grant;
   logic [RF_ADDR_W-1:0] rd_addr, wr_addr;
   logic [RF_DATA_W-1:0] wr_data;
   logic                 rd_any, wr_any, wr_we;

   assign run = (state_q == S_RUN);

   rr_arbiter #(.N(NUM_RD)) u_rd_arb (
      .req_i     (bus.rd_req_valid_i),
      .ptr_i     (rd_ptr_q),
      .advance_i (run),
      .grant_o   (rd_grant)
   );

   rr_arbiter #(.N(NUM_WR)) u_wr_arb (
      .req_i     (bus.wr_req_valid_i),
      .ptr_i     (wr_ptr_q),
      .advance_i (run),
      .grant_o   (wr_grant)
   );

   // Read mux: granted address and the pointer slot after the winner.
   always_comb begin
      rd_addr  = '0;
      rd_ptr_d = rd_ptr_q;
      for (int i = 0; i < NUM_RD; i++) begin
         if (rd_grant[i]) begin
            rd_addr  = bus.rd_req_addr_i[i*RF_ADDR_W +: RF_ADDR_W];
            rd_ptr_d = (i == NUM_RD-1) ? '0 : RPW'(i+1);
         end
      end
   end

   // Write mux: granted address/data and the next pointer.
   always_comb begin
      wr_addr  = '0;
      wr_data  = '0;
      wr_ptr_d = wr_ptr_q;
      for (int i = 0; i < NUM_WR; i++) begin
         if (wr_grant[i]) begin
            wr_addr  = bus.wr_req_addr_i[i*RF_ADDR_W +: RF_ADDR_W];
            wr_data  = bus.wr_req_data_i[i*RF_DATA_W +: RF_DATA_W];
            wr_ptr_d = (i == NUM_WR-1) ? '0 : WPW'(i+1);
         end
      end
   end

   assign rd_any = |rd_grant;
   assign wr_any = |wr_grant;
   // Writes to r0 are acknowledged but dropped when r0 is hardwired.
   assign wr_we  = wr_any && !(ZERO_R0 && (wr_addr == '0));

   // Register-file drive: clear sweep during init, granted write after.
   always_comb begin
      bus.rf_source_o  = rd_addr;
      bus.rf_dest_we_o = run ? wr_we : 1'b1;
      bus.rf_dest_o    = run ? wr_addr : cnt_q;
      bus.rf_data_w_o  = run ? wr_data : '0;
      rsp_data_d       = bus.rf_source_data_i;
      // The file only updates on this edge, so forward the new value.
      if (rd_any && wr_we && (wr_addr == rd_addr)) begin
         rsp_data_d = wr_data;
      end
   end

   assign bus.rd_req_ready_o = rd_grant;
   assign bus.wr_req_ready_o = wr_grant;
   assign bus.rd_rsp_valid_o = rsp_valid_q;
   assign bus.rd_rsp_data_o  = rsp_data_q;
   assign bus.init_done_o    = done_q;

   // Sequencer FSM, round-robin pointers and registered read response.
   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         rsp_valid_q <= rd_grant;
         unique case (state_q)
            S_INIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == RF_ADDR_W'(RF_DEPTH-1)) begin
                  state_q <= S_RUN;
                  done_q  <= 1'b1;
               end
            end
            S_RUN: begin
               rd_ptr_q <= rd_ptr_d;
               wr_ptr_q <= wr_ptr_d;
               if (rd_any) begin
                  rsp_data_q <= rsp_data_d;
               end
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile32_port_arbiter.sv
// Directed bench: clear sweep, arbitration, bypass, r0 hardwiring
// and reset mid-run / mid-sweep, against two arbiter instances.
module tb_regfile32_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile32_port_arbiter_if #(.NUM_RD(2), .NUM_WR(2)) b0 ();
   regfile32_port_arbiter_if #(.NUM_RD(2), .NUM_WR(2)) b1 ();

   regfile32_port_arbiter #(
      .NUM_RD(2), .NUM_WR(2), .ZERO_R0(1'b0)
   ) dut0 (
      .core_clock_i (clk),
      .core_reset_i (rst),
      .bus          (b0)
   );

   regfile32_port_arbiter #(
      .NUM_RD(2), .NUM_WR(2), .ZERO_R0(1'b1)
   ) dut1 (
      .core_clock_i (clk),
      .core_reset_i (rst),
      .bus          (b1)
   );

   logic [31:0] mem0 [32];
   logic [31:0] mem1 [32];

   always @(posedge clk) begin
      if (b0.rf_dest_we_o) mem0[b0.rf_dest_o] <= b0.rf_data_w_o;
      if (b1.rf_dest_we_o) mem1[b1.rf_dest_o] <= b1.rf_data_w_o;
   end

   assign b0.rf_source_data_i = mem0[b0.rf_source_o];
   assign b1.rf_source_data_i = mem1[b1.rf_source_o];

   typedef struct {
      logic [1:0]  rv;
      logic [4:0]  ra0, ra1;
      logic [1:0]  wv;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [1:0]  x_rr, x_wr;
      logic [4:0]  x_src, x_dst;
      logic        x_we;
      logic [31:0] x_wd;
      logic [1:0]  x_rv;
      logic [31:0] x_rd;
   } vec_t;

   localparam int NV = 16;
   vec_t tv [NV];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive0(input vec_t v);
      b0.rd_req_valid_i = v.rv;
      b0.rd_req_addr_i  = {v.ra1, v.ra0};
      b0.wr_req_valid_i = v.wv;
      b0.wr_req_addr_i  = {v.wa1, v.wa0};
      b0.wr_req_data_i  = {v.wd1, v.wd0};
   endtask

   task automatic drive1(input logic [1:0] rv, input logic [4:0] ra,
                         input logic [1:0] wv, input logic [4:0] wa,
                         input logic [31:0] wd);
      b1.rd_req_valid_i = rv;
      b1.rd_req_addr_i  = {5'd0, ra};
      b1.wr_req_valid_i = wv;
      b1.wr_req_addr_i  = {5'd0, wa};
      b1.wr_req_data_i  = {32'd0, wd};
   endtask

   task automatic idle0();
      b0.rd_req_valid_i = '0;
      b0.rd_req_addr_i  = '0;
      b0.wr_req_valid_i = '0;
      b0.wr_req_addr_i  = '0;
      b0.wr_req_data_i  = '0;
   endtask

   localparam logic [31:0] A = 32'hDEADBEEF;
   localparam logic [31:0] B = 32'h12345678;
   localparam logic [31:0] C = 32'hA0A0A0A0;
   localparam logic [31:0] D = 32'hB1B1B1B1;
   localparam logic [31:0] E = 32'h00000011;

   initial begin
      //       rv     ra0 ra1  wv     wa0 wa1 wd0 wd1
      //       rr     wr     src dst we  wd  rv     rd
      tv[0]  = '{2'b00, 0, 0,  2'b01, 5, 0,  A, 0,
                 2'b00, 2'b01, 0, 5,  1, A, 2'b00, 0};
      tv[1]  = '{2'b10, 0, 5,  2'b00, 0, 0,  0, 0,
                 2'b10, 2'b00, 5, 0,  0, 0, 2'b10, A};
      tv[2]  = '{2'b01, 7, 0,  2'b10, 0, 7,  0, B,
                 2'b01, 2'b10, 7, 7,  1, B, 2'b01, B};
      tv[3]  = '{2'b10, 0, 7,  2'b00, 0, 0,  0, 0,
                 2'b10, 2'b00, 7, 0,  0, 0, 2'b10, B};
      for (int i = 4; i < 10; i += 2) begin
         tv[i]   = '{2'b11, 5, 7, 2'b11, 10, 11, C, D,
                     2'b01, 2'b01, 5, 10, 1, C, 2'b01, A};
         tv[i+1] = '{2'b11, 5, 7, 2'b11, 10, 11, C, D,
                     2'b10, 2'b10, 7, 11, 1, D, 2'b10, B};
      end
      tv[10] = '{2'b11, 10, 11, 2'b00, 0, 0, 0, 0,
                 2'b01, 2'b00, 10, 0, 0, 0, 2'b01, C};
      tv[11] = '{2'b11, 10, 11, 2'b00, 0, 0, 0, 0,
                 2'b10, 2'b00, 11, 0, 0, 0, 2'b10, D};
      tv[12] = '{2'b00, 0, 0,  2'b00, 0, 0,  0, 0,
                 2'b00, 2'b00, 0, 0,  0, 0, 2'b00, D};
      tv[13] = '{2'b10, 0, 10, 2'b00, 0, 0,  0, 0,
                 2'b10, 2'b00, 10, 0, 0, 0, 2'b10, C};
      tv[14] = '{2'b01, 0, 0,  2'b10, 0, 0,  0, E,
                 2'b01, 2'b10, 0, 0,  1, E, 2'b01, E};
      tv[15] = '{2'b01, 0, 0,  2'b00, 0, 0,  0, 0,
                 2'b01, 2'b00, 0, 0,  0, 0, 2'b01, E};

      // Reset with every request held on dut0.
      b0.rd_req_valid_i = 2'b11;
      b0.rd_req_addr_i  = {5'd3, 5'd4};
      b0.wr_req_valid_i = 2'b11;
      b0.wr_req_addr_i  = {5'd6, 5'd9};
      b0.wr_req_data_i  = {32'h1, 32'h2};
      drive1(2'b00, 0, 2'b00, 0, 0);
      @(negedge clk);
      #1;
      chk("rst_rsp_valid", 32'(b0.rd_rsp_valid_o), 0);
      chk("rst_rsp_data", b0.rd_rsp_data_o, 0);
      chk("rst_init_done", 32'(b0.init_done_o), 0);
      chk("rst_rd_ready", 32'(b0.rd_req_ready_o), 0);
      chk("rst_wr_ready", 32'(b0.wr_req_ready_o), 0);
      @(negedge clk);
      rst = 1'b0;

      // Clear sweep: one write per cycle, address equals cycle.
      for (int c = 0; c < 32; c++) begin
         #1;
         chk($sformatf("sweep_we[%0d]", c), 32'(b0.rf_dest_we_o), 1);
         chk($sformatf("sweep_dst[%0d]", c), 32'(b0.rf_dest_o), c);
         chk($sformatf("sweep_wd[%0d]", c), b0.rf_data_w_o, 0);
         chk($sformatf("sweep_rdy[%0d]", c),
             32'({b0.rd_req_ready_o, b0.wr_req_ready_o}), 0);
         chk($sformatf("sweep_done[%0d]", c), 32'(b0.init_done_o), 0);
         @(negedge clk);
      end
      idle0();
      #1;
      chk("init_done_c32", 32'(b0.init_done_o), 1);
      chk("init_done_dut1", 32'(b1.init_done_o), 1);
      chk("init_rsp_valid", 32'(b0.rd_rsp_valid_o), 0);
      @(negedge clk);

      // Table-driven arbitration / bypass vectors on dut0.
      for (int i = 0; i < NV; i++) begin
         drive0(tv[i]);
         #1;
         chk($sformatf("v%0d_rd_ready", i),
             32'(b0.rd_req_ready_o), 32'(tv[i].x_rr));
         chk($sformatf("v%0d_wr_ready", i),
             32'(b0.wr_req_ready_o), 32'(tv[i].x_wr));
         chk($sformatf("v%0d_src", i),
             32'(b0.rf_source_o), 32'(tv[i].x_src));
         chk($sformatf("v%0d_we", i),
             32'(b0.rf_dest_we_o), 32'(tv[i].x_we));
         if (tv[i].x_we) begin
            chk($sformatf("v%0d_dst", i),
                32'(b0.rf_dest_o), 32'(tv[i].x_dst));
            chk($sformatf("v%0d_wd", i), b0.rf_data_w_o, tv[i].x_wd);
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_rsp_valid", i),
             32'(b0.rd_rsp_valid_o), 32'(tv[i].x_rv));
         chk($sformatf("v%0d_rsp_data", i), b0.rd_rsp_data_o, tv[i].x_rd);
         @(negedge clk);
      end
      idle0();

      // dut1 hardwires r0: write acknowledged, file untouched.
      drive1(2'b01, 0, 2'b01, 0, 32'hFFFFFFFF);
      #1;
      chk("z_wr_ready", 32'(b1.wr_req_ready_o), 1);
      chk("z_we", 32'(b1.rf_dest_we_o), 0);
      chk("z_rd_ready", 32'(b1.rd_req_ready_o), 1);
      @(posedge clk);
      #1;
      chk("z_rsp_valid0", 32'(b1.rd_rsp_valid_o), 1);
      chk("z_rsp_data0", b1.rd_rsp_data_o, 0);
      @(negedge clk);
      drive1(2'b01, 0, 2'b00, 0, 0);
      @(posedge clk);
      #1;
      chk("z_rsp_valid1", 32'(b1.rd_rsp_valid_o), 1);
      chk("z_rsp_data1", b1.rd_rsp_data_o, 0);
      @(negedge clk);
      drive1(2'b01, 3, 2'b01, 3, 32'h5A5A5A5A);
      #1;
      chk("z_we_r3", 32'(b1.rf_dest_we_o), 1);
      @(posedge clk);
      #1;
      chk("z_bypass_r3", b1.rd_rsp_data_o, 32'h5A5A5A5A);
      @(negedge clk);
      drive1(2'b00, 0, 2'b00, 0, 0);

      // Reset mid-run discards an in-flight response at once.
      b0.rd_req_valid_i = 2'b01;
      b0.rd_req_addr_i  = {5'd0, 5'd5};
      @(posedge clk);
      #1;
      chk("run_rsp_before_rst", 32'(b0.rd_rsp_valid_o), 1);
      chk("run_rsp_data_before_rst", b0.rd_rsp_data_o, A);
      rst = 1'b1;
      #1;
      chk("run_rst_rsp_valid", 32'(b0.rd_rsp_valid_o), 0);
      chk("run_rst_rsp_data", b0.rd_rsp_data_o, 0);
      chk("run_rst_done", 32'(b0.init_done_o), 0);
      chk("run_rst_rd_ready", 32'(b0.rd_req_ready_o), 0);
      idle0();
      @(negedge clk);
      rst = 1'b0;

      // Reset again at sweep count 10; sweep restarts from 0.
      for (int c = 0; c < 10; c++) @(negedge clk);
      #1;
      chk("mid_dst10", 32'(b0.rf_dest_o), 10);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_dst", 32'(b0.rf_dest_o), 0);
      chk("mid_rst_done", 32'(b0.init_done_o), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 32; c++) begin
         #1;
         if (c == 0 || c == 31) begin
            chk($sformatf("re_dst[%0d]", c), 32'(b0.rf_dest_o), c);
         end
         chk($sformatf("re_done[%0d]", c), 32'(b0.init_done_o), 0);
         @(negedge clk);
      end
      #1;
      chk("re_done_c32", 32'(b0.init_done_o), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
